lcd_ctrl: RTL

Sequencing controller for the character-LCD output word of the peripheral memory. Accepts LCD command and data bytes from the LSU through a valid/ready handshake and buffers them in a small FIFO. Replays each byte as a timed RS/EN/DATA waveform on a 32-bit word in the LCD register format, so software never bit-bangs the EN strobe or waits out command latencies. Sits between the LSU store path and the LCD pins, next to the LED/HEX output registers.

---
 rtl/lcd_ctrl_pkg.sv | 33 +++
 rtl/lcd_ctrl_fifo.sv | 52 +++++
 rtl/lcd_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types and constants for the character-LCD sequencer
//
// Contents: FSM state enum, o_io_lcd bit positions, clear/home opcodes,
// the power-on init ROM and a helper that classifies long-latency commands.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RS_BIT = 9;
  localparam int LCD_RW_BIT = 8;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Init sequence: function set, display on, clear, entry mode (index 0 first).
  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Clear/home commands need the long post-hold wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_ctrl_fifo.sv
// rtl/lcd_ctrl_fifo.sv - request FIFO of {rs,data} entries
//
// Module lcd_cmd_fifo. Ports:
//   i_clk, i_rst      clock, async active-high reset (flushes the FIFO)
//   i_push, i_wdata   write strobe and 9-bit entry (ignored when full)
//   i_pop             read strobe (ignored when empty)
//   o_rdata           head entry, valid while o_empty=0
//   o_full, o_empty   occupancy flags
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - timed RS/EN/DATA sequencer for the character-LCD output word
//
// Optional feature macro: LCD_CTRL_INIT_EN (power-up delay + init ROM replay).
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_req_valid / o_req_ready     request handshake, transfer on valid & ready
//   i_req_rs, i_req_data          0=command / 1=character, byte to send
//   i_lcd_on                      passed combinationally to o_io_lcd[31]
//   o_io_lcd                      [31] ON, [10] EN, [9] RS, [8] RW=0, [7:0] DATA
//   o_busy                        FSM active, FIFO non-empty, or init pending
//   o_init_done                   power-on init finished (1 when init disabled)
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 12,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  input  logic        i_lcd_on,
  output logic [31:0] o_io_lcd,
  output logic        o_busy,
  output logic        o_init_done
);

  localparam int CW = $clog2(CLR_WAIT_CYC + 1);
  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(CLR_WAIT_CYC - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_cur_rs, w_cur_rs_nxt;
  logic [7:0]    r_cur_data, w_cur_data_nxt;
  logic          w_fifo_pop;
  logic [8:0]    w_fifo_rdata;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  // Output stage: one register between FSM and pins keeps EN glitch-free.
  logic          r_out_en;
  logic          r_out_rs;
  logic [7:0]    r_out_data;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_req_valid),
    .i_wdata ({i_req_rs, i_req_data}),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_req_ready = !w_fifo_full;

`ifdef LCD_CTRL_INIT_EN
  logic       r_pwr_done, w_pwr_done_nxt;
  logic [2:0] r_init_idx, w_init_idx_nxt;
  logic       r_init_done, w_init_done_nxt;

  assign o_init_done = r_init_done;
  assign o_busy      = (r_state != ST_IDLE) || !w_fifo_empty || !r_init_done;
`else
  assign o_init_done = 1'b1;
  assign o_busy      = (r_state != ST_IDLE) || !w_fifo_empty;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cur_rs_nxt   = r_cur_rs;
    w_cur_data_nxt = r_cur_data;
    w_fifo_pop     = 1'b0;
`ifdef LCD_CTRL_INIT_EN
    w_pwr_done_nxt  = r_pwr_done;
    w_init_idx_nxt  = r_init_idx;
    w_init_done_nxt = r_init_done;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef LCD_CTRL_INIT_EN
        // Power-up delay reuses the down-counter while parked in IDLE.
        if (!r_pwr_done) begin
          if (r_cnt == '0) w_pwr_done_nxt = 1'b1;
          else             w_cnt_nxt      = r_cnt - 1'b1;
        end else if (r_init_idx != 3'(INIT_LEN)) begin
          w_cur_rs_nxt   = 1'b0;
          w_cur_data_nxt = INIT_ROM[r_init_idx[1:0]];
          w_init_idx_nxt = r_init_idx + 3'd1;
          w_state_nxt    = ST_SETUP;
          w_cnt_nxt      = L_SETUP;
        end else begin
          w_init_done_nxt = 1'b1;
          if (!w_fifo_empty) begin
            w_fifo_pop     = 1'b1;
            w_cur_rs_nxt   = w_fifo_rdata[8];
            w_cur_data_nxt = w_fifo_rdata[7:0];
            w_state_nxt    = ST_SETUP;
            w_cnt_nxt      = L_SETUP;
          end
        end
`else
        if (!w_fifo_empty) begin
          w_fifo_pop     = 1'b1;
          w_cur_rs_nxt   = w_fifo_rdata[8];
          w_cur_data_nxt = w_fifo_rdata[7:0];
          w_state_nxt    = ST_SETUP;
          w_cnt_nxt      = L_SETUP;
        end
`endif
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = L_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = L_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = is_long_cmd(r_cur_rs, r_cur_data) ? L_CLR : L_CMD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cur_rs   <= 1'b0;
      r_cur_data <= 8'h00;
`ifdef LCD_CTRL_INIT_EN
      r_cnt       <= L_CLR;
      r_pwr_done  <= 1'b0;
      r_init_idx  <= 3'd0;
      r_init_done <= 1'b0;
`else
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_rs   <= w_cur_rs_nxt;
      r_cur_data <= w_cur_data_nxt;
`ifdef LCD_CTRL_INIT_EN
      r_pwr_done  <= w_pwr_done_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_init_done <= w_init_done_nxt;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_en   <= 1'b0;
      r_out_rs   <= 1'b0;
      r_out_data <= 8'h00;
    end else begin
      r_out_en   <= (r_state == ST_PULSE);
      r_out_rs   <= r_cur_rs;
      r_out_data <= r_cur_data;
    end
  end

  always_comb begin
    o_io_lcd             = 32'h0;
    o_io_lcd[LCD_ON_BIT] = i_lcd_on;
    o_io_lcd[LCD_EN_BIT] = r_out_en;
    o_io_lcd[LCD_RS_BIT] = r_out_rs;
    o_io_lcd[LCD_RW_BIT] = 1'b0;
    o_io_lcd[7:0]        = r_out_data;
  end

endmodule
